// File: rtl/fetch_pkg.sv
// Shared state encoding and field constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FULL
  } fetchState_e;

  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID holding register: captures a fetched word with its PC and holds it
// until the decode stage consumes it or a redirect flushes it.
module fetch_ifid_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pcPlus4_q;
  logic               valid_q;

  // Flush only kills the valid bit; the stale payload is never observed as live.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_q   <= '0;
      pc_q      <= '0;
      pcPlus4_q <= ADDR_W'(PC_STEP);
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pc_q      <= pc_i;
      pcPlus4_q <= pc_i + ADDR_W'(PC_STEP);
      valid_q   <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pcPlus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory handshake and IF/ID.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets and halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [5:0]         op_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  output logic               instr_valid_o,
  output logic               misalign_o
);

  fetchState_e       state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              discard_q;
  logic              redirBad;
  logic              halted;
  logic              ifidLoad;
  logic              ifidFlush;
  logic [ADDR_W-1:0] redirTarget;

  assign redirTarget = redirect_pc_i & {{(ADDR_W-2){1'b1}}, 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign redirBad = redirect_i && (redirect_pc_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      misalign_q <= 1'b0;
    end else if (redirBad) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign redirBad   = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign halted = misalign_o;

  assign imem_req_o  = (state_q == REQ) && !redirect_i;
  assign imem_addr_o = pc_q;

  assign ifidLoad  = (state_q == WAIT) && imem_rvalid_i && !discard_q && !redirect_i;
  assign ifidFlush = redirect_i || ((state_q == FULL) && !stall_i);

  // A response that arrives after a redirect belongs to the wrong path and is dropped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
    end else if (redirBad) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
    end else begin
      if (redirect_i) begin
        pc_q <= redirTarget;
      end
      case (state_q)
        IDLE: begin
          if (!halted) begin
            state_q <= REQ;
          end
        end
        REQ: begin
          if (!redirect_i) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            discard_q <= 1'b0;
            if (redirect_i || discard_q) begin
              state_q <= REQ;
            end else begin
              state_q <= FULL;
              pc_q    <= pc_q + ADDR_W'(PC_STEP);
            end
          end else if (redirect_i) begin
            discard_q <= 1'b1;
          end
        end
        FULL: begin
          if (redirect_i || !stall_i) begin
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_ifid_reg #(
    .ADDR_W(ADDR_W)
  ) uIfid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ifidLoad),
    .flush_i    (ifidFlush),
    .instr_i    (imem_rdata_i),
    .pc_i       (pc_q),
    .instr_o    (instr_o),
    .pc_o       (pc_o),
    .pc_plus4_o (pc_plus4_o),
    .valid_o    (instr_valid_o)
  );

  assign op_o = instr_o[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a transaction-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, redir, rvalid;
  logic [31:0] redirPc, rdata;

  logic        req, req2;
  logic [31:0] addr, addr2, instr, instr2, pc, pc2, pcPlus4, pcPlus42;
  logic [5:0]  op, op2;
  logic        valid, valid2, misalign, misalign2;

  int testsRun = 0;
  int failCount = 0;

  // Transaction-level model state for the randomized phase
  logic [31:0] expPc, outAddr, delAddr, curAddr, memAddr, tgt, word;
  logic        outstanding, wrongPath, deliverNext, expValid;
  logic        prevValid, prevStall, prevRedir, rv, s, r;
  int          memCnt, idleCount, reqSeen;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (redirPc),
    .instr_o       (instr),
    .op_o          (op),
    .pc_o          (pc),
    .pc_plus4_o    (pcPlus4),
    .instr_valid_o (valid),
    .misalign_o    (misalign)
  );

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) dutWrap (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .imem_req_o    (req2),
    .imem_addr_o   (addr2),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .instr_o       (instr2),
    .op_o          (op2),
    .pc_o          (pc2),
    .pc_plus4_o    (pcPlus42),
    .instr_valid_o (valid2),
    .misalign_o    (misalign2)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the rising edge; the caller samples at the falling edge.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic rvl, input logic [31:0] dat);
    @(posedge clk);
    #1;
    stall   = st;
    redir   = rd;
    redirPc = rpc;
    rvalid  = rvl;
    rdata   = dat;
    @(negedge clk);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    stall  = 1'b0;
    redir  = 1'b0;
    rvalid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    stall = 1'b0; redir = 1'b0; redirPc = '0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst_req", req, 0);
    checkOutput("rst_addr", addr, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_op", op, 0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_pc4", pcPlus4, 32'h4);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_misalign", misalign, 0);
    checkOutput("rst_wrap_addr", addr2, 32'hFFFF_FFFC);
    checkOutput("rst_wrap_misc", {instr2[15:0], op2, pc2[3:0], pcPlus42[3:0], valid2, misalign2},
                {16'h0, 6'h0, 4'h0, 4'h4, 1'b0, 1'b0});

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_req", req, 0);

    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("first_req", req, 1);
    checkOutput("first_addr", addr, 32'h0);
    checkOutput("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1, 32'h0000_0000);
    checkOutput("wait_no_req", req, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("i0_valid", valid, 1);
    checkOutput("i0_op", op, 6'b000000);
    checkOutput("i0_pc", pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("second_req", req, 1);
    checkOutput("second_addr", addr, 32'h4);
    checkOutput("wrap_second_addr", addr2, 32'h0);
    checkOutput("consumed_valid", valid, 0);
    applyStimulus(0, 0, 0, 1, 32'h2008_0005);

    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("i1_valid", valid, 1);
    checkOutput("i1_op", op, 6'b001000);
    checkOutput("i1_pc", pc, 32'h4);
    checkOutput("i1_pc4", pcPlus4, 32'h8);
    checkOutput("i1_instr", instr, 32'h2008_0005);
    repeat (4) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("stall_instr", instr, 32'h2008_0005);
      checkOutput("stall_pc", pc, 32'h4);
      checkOutput("stall_req", req, 0);
      checkOutput("stall_valid", valid, 1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("unstall_cycle_req", req, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post_stall_req", req, 1);
    checkOutput("post_stall_addr", addr, 32'h8);

    applyStimulus(0, 1, 32'h40, 0, 0);
    checkOutput("redir_wait_req", req, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("drop_valid_a", valid, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drop_valid_b", valid, 0);
    checkOutput("redir_req", req, 1);
    checkOutput("redir_addr", addr, 32'h40);

    applyStimulus(0, 0, 0, 1, 32'h1111_0000);
    applyStimulus(1, 1, 32'h80, 0, 0);
    checkOutput("full_valid", valid, 1);
    checkOutput("full_pc", pc, 32'h40);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("flush_valid", valid, 0);
    checkOutput("flush_req", req, 1);
    checkOutput("flush_addr", addr, 32'h80);

    @(posedge clk);
    #1;
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; rvalid = 1'b0;
    #1;
    checkOutput("async_req", req, 0);
    checkOutput("async_addr", addr, 32'h0);
    checkOutput("async_pc", pc, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    expPc = 32'h0; outAddr = '0; delAddr = '0; curAddr = '0; memAddr = '0;
    outstanding = 0; wrongPath = 0; deliverNext = 0;
    prevValid = 0; prevStall = 0; prevRedir = 0;
    memCnt = 0; idleCount = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      rv = 1'b0;
      if (memCnt > 0) begin
        memCnt--;
        rv = (memCnt == 0);
      end
      s   = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 63)) << 2);
      applyStimulus(s, r, tgt, rv, rv ? memWord(memAddr) : 32'h0);

      expValid = deliverNext || (prevValid && prevStall && !prevRedir);
      checkOutput("rnd_valid", valid, expValid);
      if (deliverNext) curAddr = delAddr;
      if (expValid) begin
        word = memWord(curAddr);
        checkOutput("rnd_pc", pc, curAddr);
        checkOutput("rnd_instr", instr, word);
        checkOutput("rnd_op", op, word[31:26]);
        checkOutput("rnd_pc4", pcPlus4, curAddr + 32'd4);
      end
      if (r) checkOutput("rnd_req_suppress", req, 0);

      deliverNext = 0;
      if (rv) begin
        outstanding = 0;
        if (!wrongPath && !r) begin
          deliverNext = 1;
          delAddr     = outAddr;
          expPc       = outAddr + 32'd4;
        end
      end
      if (req) begin
        checkOutput("rnd_one_outstanding", outstanding, 0);
        checkOutput("rnd_addr", addr, expPc);
        outstanding = 1;
        wrongPath   = 0;
        outAddr     = expPc;
        memAddr     = expPc;
        memCnt      = $urandom_range(1, 3);
      end
      if (r) begin
        expPc = tgt;
        if (outstanding) wrongPath = 1;
      end

      if (req || valid) idleCount = 0;
      else idleCount++;
      checkOutput("rnd_liveness", idleCount > 12, 0);

      prevValid = valid;
      prevStall = s;
      prevRedir = r;
    end

    doReset();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mis_first_req", req, 1);
    applyStimulus(0, 0, 0, 1, 32'h0);
    applyStimulus(0, 1, 32'h42, 0, 0);
    checkOutput("mis_pre_valid", valid, 1);
`ifdef FETCH_ALIGN_CHECK_EN
    reqSeen = 0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mis_flag", misalign, 1);
    checkOutput("mis_valid", valid, 0);
    if (req) reqSeen++;
    repeat (8) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (req) reqSeen++;
    end
    checkOutput("mis_halt", reqSeen, 0);
    checkOutput("mis_sticky", misalign, 1);
`else
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mis_req", req, 1);
    checkOutput("mis_addr", addr, 32'h40);
    checkOutput("mis_flag", misalign, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the opcode decoder. Holds the program counter, issues one instruction-memory read at a time over a request/valid handshake, and captures the returned word into an IF/ID holding register. Exposes the instruction, its opcode field and its PC to the decode stage. Supports downstream stall and branch redirect, with flush of wrong-path instructions.

## Interface
Parameters:
- `ADDR_W`, 32: PC and memory address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `imem_req_o`  out  1  fetch request; one-cycle pulse per fetch.
- `imem_addr_o`  out  ADDR_W  fetch address; valid while `imem_req_o`=1.
- `imem_rvalid_i`  in  1  read data valid; at least 1 cycle after the request.
- `imem_rdata_i`  in  32  instruction word.
- `stall_i`  in  1  downstream hold; the instruction is not consumed this cycle.
- `redirect_i`  in  1  taken branch; replaces PC, flushes.
- `redirect_pc_i`  in  ADDR_W  branch target.
- `instr_o`  out  32  IF/ID instruction.
- `op_o`  out  6  `instr_o[31:26]`, to the decoder opcode input.
- `pc_o`  out  ADDR_W  address of `instr_o`.
- `pc_plus4_o`  out  ADDR_W  `pc_o`+4, for branch-target adders.
- `instr_valid_o`  out  1  IF/ID holds a live instruction.
- `misalign_o`  out  1  see Configuration.

## Operation
- States:
  - IDLE: reset state; goes to REQ.
  - REQ: drives `imem_req_o`=1 with `imem_addr_o`=`pc_q`; goes to WAIT.
  - WAIT: one request outstanding.
    - On `imem_rvalid_i` with discard clear: latch `imem_rdata_i` and `pc_q` into IF/ID, set valid, `pc_q`+=4, go to FULL.
    - On `imem_rvalid_i` with discard set: drop the data, clear discard, go to REQ.
  - FULL: IF/ID occupied.
    - `stall_i`=0: clear valid and go to REQ.
    - `stall_i`=1: hold every IF/ID output unchanged.
- Redirect has priority over `stall_i` and `imem_rvalid_i`. Its effect depends on state:
  - REQ: `imem_req_o` is suppressed that cycle; `pc_q`<=`redirect_pc_i`; stay in REQ.
  - WAIT: `pc_q`<=target; set discard. If `imem_rvalid_i` arrives the same cycle, drop the data and go straight to REQ.
  - FULL: clear valid; `pc_q`<=target; go to REQ.
  - IDLE: `pc_q`<=target.
- `imem_rvalid_i` is ignored outside WAIT.
- Only one request is outstanding at a time; there is no second request before the response.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC+4 wraps to 0.
- `imem_req_o` is combinational from state and `redirect_i`. All other outputs are registered.

## Timing
- Reset values:
  - `imem_req_o`=0, `imem_addr_o`=RESET_PC.
  - `instr_o`=0, `op_o`=0, `pc_o`=0, `pc_plus4_o`=4.
  - `instr_valid_o`=0, `misalign_o`=0, discard=0.
  - `pc_q`=RESET_PC, state IDLE.
- First request: 2nd rising edge after `rst_i` deasserts (IDLE then REQ).
- Latency: `instr_valid_o` rises the cycle after the edge that samples `imem_rvalid_i`.
- Throughput with 1-cycle memory and no stall: one instruction every 3 cycles.
- Reset asserted mid-operation: all state clears immediately. The memory is reset by the same `rst_i`, so there are no stale responses.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc_i[1:0]`≠0 sets `misalign_o`=1 (sticky until reset).
  - The unit then enters IDLE and halts: no further requests.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `redirect_pc_i[1:0]` is forced to 0 when loaded.
  - `misalign_o` is tied to 0.

## Structure
- Package `fetch_pkg` holds:
  - state enum (IDLE, REQ, WAIT, FULL);
  - `INSTR_W`=32, `OP_MSB`=31, `OP_LSB`=26;
  - `PC_STEP`=4.
- Sub-module `fetch_ifid_reg` holds the IF/ID register: instr/pc/valid with load, hold and flush controls.
- The state machine and PC stay in `fetch_unit`.

## Test plan
- Reset then 1-cycle memory returning 32'h0000_0000, then 32'h2008_0005 -> requests at 0 and 4; `op_o`=6'b000000, then 6'b001000; `pc_o`=0, then 4.
- `stall_i`=1 for 5 cycles while FULL -> `instr_o`/`pc_o` frozen, no `imem_req_o`; next request is issued the cycle after `stall_i` drops.
- Redirect to 32'h40 while WAIT, response arrives 2 cycles later -> data dropped, `instr_valid_o` stays 0, next request at 32'h40.
- Redirect to 32'h80 while FULL with `stall_i`=1 -> valid cleared next cycle, request at 32'h80.
- RESET_PC=32'hFFFF_FFFC -> second request at 32'h0000_0000.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 32'h42 -> `misalign_o`=1, no further requests; without it -> request at 32'h40.
